// File: rtl/bsearch_sequencer.sv
// Binary-search engine over an ascending-sorted synchronous-read RAM.
// Owns the search bounds, drives the RAM address and waits out the read latency before each compare.
module bsearch_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] target,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W-1:0] index,
   output logic [ADDR_W:0]   probes
);

   typedef enum logic [2:0] {IDLE, CALC, WAIT, CMP, DONE} state_t;

   localparam logic [1:0]    LAT     = 2'(RD_LAT);
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] TOP   = {1'b0, {ADDR_W{1'b1}}};

   state_t              state;
   logic [DATA_W-1:0]   targetReg;
   logic [ADDR_W:0]     lower;
   logic [ADDR_W:0]     upper;
   logic [ADDR_W-1:0]   mid;
   logic [1:0]          waitCnt;
   logic [ADDR_W:0]     midSum;
   logic [ADDR_W-1:0]   midCalc;

   // Bounds are one bit wider than the address so lower=2^ADDR_W and upper=-1 stay distinct.
   assign midSum  = lower + upper;
   assign midCalc = midSum[ADDR_W:1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         targetReg <= '0;
         lower     <= '0;
         upper     <= '0;
         mid       <= '0;
         waitCnt   <= '0;
         ram_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         index     <= '0;
         probes    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  targetReg <= target;
                  lower     <= '0;
                  upper     <= TOP;
                  found     <= 1'b0;
                  index     <= '0;
                  probes    <= '0;
                  busy      <= 1'b1;
                  state     <= CALC;
               end
            end
            CALC: begin
               if (lower > upper) begin
                  found <= 1'b0;
                  index <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  mid      <= midCalc;
                  ram_addr <= midCalc;
                  waitCnt  <= LAT;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               waitCnt <= waitCnt - 2'd1;
               if (waitCnt == 2'd1) begin
                  state <= CMP;
               end
            end
            CMP: begin
               probes <= probes + ONE;
               if (ram_rdata == targetReg) begin
                  found <= 1'b1;
                  index <= mid;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (ram_rdata < targetReg) begin
                  lower <= {1'b0, mid} + ONE;
                  state <= CALC;
               end else if (mid == '0) begin
                  // Nothing below address 0: stop here rather than wrap upper.
                  found <= 1'b0;
                  index <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  upper <= {1'b0, mid} - ONE;
                  state <= CALC;
               end
            end
            DONE: begin
               if (!start) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bsearch_sequencer.sv
// Directed bench for bsearch_sequencer: one RD_LAT=1 and one RD_LAT=3 instance, each with its own RAM model.
// Expected results and probe addresses go into queues at stimulus time and are consumed as the DUT runs.
module tb_bsearch_sequencer;

   localparam int AW = 5;
   localparam int DW = 8;

   typedef struct {
      logic          found;
      logic [AW-1:0] index;
      logic [AW:0]   probes;
      int            doneCycle;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic sel;
   logic startDrv;
   logic [DW-1:0] targetDrv;

   logic startA, startB;
   logic [AW-1:0] addrA, addrB, indexA, indexB;
   logic [DW-1:0] rdataA, rdataB;
   logic busyA, busyB, doneA, doneB, foundA, foundB;
   logic [AW:0] probesA, probesB;

   logic [DW-1:0] memA [32];
   logic [DW-1:0] memB [32];
   logic [DW-1:0] pipeA;
   logic [DW-1:0] pipeB [3];

   exp_t          sbq [$];
   logic [AW-1:0] addrQ [$];
   exp_t          lastExp;
   int            plan [6];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   assign startA = startDrv & ~sel;
   assign startB = startDrv & sel;

   bsearch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dutA (
      .clk(clk), .reset(reset), .start(startA), .target(targetDrv),
      .ram_addr(addrA), .ram_rdata(rdataA), .busy(busyA), .done(doneA),
      .found(foundA), .index(indexA), .probes(probesA)
   );

   bsearch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dutB (
      .clk(clk), .reset(reset), .start(startB), .target(targetDrv),
      .ram_addr(addrB), .ram_rdata(rdataB), .busy(busyB), .done(doneB),
      .found(foundB), .index(indexB), .probes(probesB)
   );

   // RAM models: data appears RD_LAT clocks after the address register changes.
   always @(posedge clk) begin
      pipeA    <= memA[addrA];
      pipeB[0] <= memB[addrB];
      pipeB[1] <= pipeB[0];
      pipeB[2] <= pipeB[1];
   end
   assign rdataA = pipeA;
   assign rdataB = pipeB[2];

   wire [AW-1:0] obsAddr   = sel ? addrB   : addrA;
   wire          obsBusy   = sel ? busyB   : busyA;
   wire          obsDone   = sel ? doneB   : doneA;
   wire          obsFound  = sel ? foundB  : foundA;
   wire [AW-1:0] obsIndex  = sel ? indexB  : indexA;
   wire [AW:0]   obsProbes = sel ? probesB : probesA;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Queue the expected outcome and probe addresses (from plan[]) then raise start.
   task automatic applyStimulus(input logic [DW-1:0] t, input logic f, input int idx,
                                input int np, input bit extraCalc);
      exp_t e;
      int   lat;
      lat         = sel ? 3 : 1;
      e.found     = f;
      e.index     = AW'(idx);
      e.probes    = (AW+1)'(np);
      e.doneCycle = np * (lat + 2) + 1 + (extraCalc ? 1 : 0);
      sbq.push_back(e);
      for (int i = 0; i < np; i++) addrQ.push_back(AW'(plan[i]));
      targetDrv = t;
      startDrv  = 1'b1;
   endtask

   // Follow one search cycle by cycle; doneCycle counts the accepting cycle as 1.
   task automatic runSearch(input bit changeTarget, input int abortAt);
      exp_t          e;
      int            lat;
      int            n;
      bit            finished;
      logic [AW-1:0] curAddr;
      e        = sbq[0];
      lat      = sel ? 3 : 1;
      curAddr  = '0;
      finished = 1'b0;
      n        = 0;
      @(posedge clk); #1;
      checkOutput("busy_after_accept", 32'(obsBusy), 32'd1);
      checkOutput("done_after_accept", 32'(obsDone), 32'd0);
      while (!finished && n < 300) begin
         @(posedge clk); #1;
         n++;
         if (((n - 1) % (lat + 2)) == 0 && addrQ.size() > 0) curAddr = addrQ.pop_front();
         checkOutput("ram_addr", 32'(obsAddr), 32'(curAddr));
         if (changeTarget && n == 4) targetDrv = 8'd99;
         if (abortAt == n) begin
            reset    = 1'b1;
            startDrv = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            checkOutput("abort_busy", 32'(obsBusy), 32'd0);
            checkOutput("abort_done", 32'(obsDone), 32'd0);
            checkOutput("abort_found", 32'(obsFound), 32'd0);
            checkOutput("abort_index", 32'(obsIndex), 32'd0);
            checkOutput("abort_probes", 32'(obsProbes), 32'd0);
            checkOutput("abort_addr", 32'(obsAddr), 32'd0);
            sbq.delete();
            addrQ.delete();
            for (int i = 0; i < 4; i++) begin
               @(posedge clk); #1;
               checkOutput("abort_no_done", 32'(obsDone), 32'd0);
            end
            return;
         end
         if (obsDone) finished = 1'b1;
         else checkOutput("busy_during", 32'(obsBusy), 32'd1);
      end
      if (!finished) begin
         checkOutput("done_timeout", 32'd0, 32'd1);
         return;
      end
      e = sbq.pop_front();
      lastExp = e;
      checkOutput("found", 32'(obsFound), 32'(e.found));
      checkOutput("index", 32'(obsIndex), 32'(e.index));
      checkOutput("probes", 32'(obsProbes), 32'(e.probes));
      checkOutput("done_cycle", 32'(n + 1), 32'(e.doneCycle));
      checkOutput("busy_at_done", 32'(obsBusy), 32'd0);
   endtask

   task automatic holdDone(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_done", 32'(obsDone), 32'd1);
         checkOutput("hold_busy", 32'(obsBusy), 32'd0);
         checkOutput("hold_found", 32'(obsFound), 32'(lastExp.found));
         checkOutput("hold_index", 32'(obsIndex), 32'(lastExp.index));
         checkOutput("hold_probes", 32'(obsProbes), 32'(lastExp.probes));
      end
   endtask

   task automatic endSearch();
      startDrv = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle_done", 32'(obsDone), 32'd0);
      checkOutput("idle_busy", 32'(obsBusy), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      sel       = 1'b0;
      startDrv  = 1'b0;
      targetDrv = '0;
      for (int i = 0; i < 32; i++) begin
         memA[i] = 8'(2 * i);
         memB[i] = 8'(2 * i);
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_addrA", 32'(addrA), 32'd0);
      checkOutput("rst_busyA", 32'(busyA), 32'd0);
      checkOutput("rst_doneA", 32'(doneA), 32'd0);
      checkOutput("rst_foundA", 32'(foundA), 32'd0);
      checkOutput("rst_indexA", 32'(indexA), 32'd0);
      checkOutput("rst_probesA", 32'(probesA), 32'd0);
      checkOutput("rst_busyB", 32'(busyB), 32'd0);
      checkOutput("rst_doneB", 32'(doneB), 32'd0);
      checkOutput("rst_addrB", 32'(addrB), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] RD_LAT=1, mem[i]=2i");
      plan = '{15, 7, 11, 9, 10, 0};
      applyStimulus(8'd20, 1'b1, 10, 5, 1'b0); runSearch(1'b0, 0); endSearch();
      plan = '{15, 7, 11, 9, 10, 0};
      applyStimulus(8'd21, 1'b0, 0, 5, 1'b1); runSearch(1'b0, 0); endSearch();
      plan = '{15, 23, 27, 29, 30, 31};
      applyStimulus(8'd62, 1'b1, 31, 6, 1'b0); runSearch(1'b0, 0); endSearch();
      plan = '{15, 23, 27, 29, 30, 31};
      applyStimulus(8'd255, 1'b0, 0, 6, 1'b1); runSearch(1'b0, 0); endSearch();

      $display("[TB] RD_LAT=1, mem[i]=2i+1");
      for (int i = 0; i < 32; i++) memA[i] = 8'(2 * i + 1);
      plan = '{15, 7, 3, 1, 0, 0};
      applyStimulus(8'd0, 1'b0, 0, 5, 1'b0); runSearch(1'b0, 0); endSearch();
      plan = '{15, 7, 3, 1, 0, 0};
      applyStimulus(8'd1, 1'b1, 0, 5, 1'b0); runSearch(1'b0, 0); endSearch();
      for (int i = 0; i < 32; i++) memA[i] = 8'(2 * i);

      $display("[TB] RD_LAT=3 with target change mid-search");
      sel = 1'b1;
      plan = '{15, 7, 11, 9, 10, 0};
      applyStimulus(8'd20, 1'b1, 10, 5, 1'b0); runSearch(1'b1, 0); endSearch();
      sel = 1'b0;

      $display("[TB] reset during third probe wait");
      plan = '{15, 7, 11, 9, 10, 0};
      applyStimulus(8'd20, 1'b1, 10, 5, 1'b0); runSearch(1'b0, 7);
      plan = '{15, 23, 19, 21, 20, 0};
      applyStimulus(8'd40, 1'b1, 20, 5, 1'b0); runSearch(1'b0, 0);

      $display("[TB] hold start in DONE, then restart");
      holdDone(10);
      endSearch();
      plan = '{15, 7, 11, 9, 10, 0};
      applyStimulus(8'd20, 1'b1, 10, 5, 1'b0); runSearch(1'b0, 0); endSearch();

      checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
